// File: rtl/bias_stream_ctrl_pkg.sv
// Shared types and constants for the bias ROM streaming controller.
// Holds the FSM encoding and the skid-buffer sizing used by the top and the FIFO.
package bias_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int FIFO_DEPTH = 2;
  localparam int OCC_WIDTH  = 2;

  typedef logic [OCC_WIDTH-1:0] occ_t;

  // A one-entry table still needs a one-bit address port.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bias_skid_fifo.sv
// Two-entry skid buffer between the bias ROM read data and the output stream.
// Push and pop may coincide; the head entry is presented combinationally.
module bias_skid_fifo
  import bias_stream_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output occ_t                  occ,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the two storage words are reset because the head drives the
      // stream data port, which must read zero out of reset.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // The credit rule upstream must make this unreachable.
  push_to_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (occ == occ_t'(FIFO_DEPTH))));

endmodule

// File: rtl/bias_stream_ctrl.sv
// Sequences a layer's bias ROM and streams each word onto an ap_fifo output,
// repeating the whole table reps_i times with credit-based read control.
module bias_stream_ctrl
  import bias_stream_ctrl_pkg::*;
#(
  parameter int  MEM_SIZE   = 4,
  parameter int  DATA_WIDTH = 16,
  parameter int  REP_WIDTH  = 16,
  localparam int AW         = addr_width(MEM_SIZE)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  input  logic [REP_WIDTH-1:0]  reps_i,
  output logic                  ap_idle,
  output logic                  ap_done,
  output logic                  ap_ready,
  output logic [AW-1:0]         bias_address,
  output logic                  bias_ce,
  input  logic [DATA_WIDTH-1:0] bias_q,
  output logic [DATA_WIDTH-1:0] output_V_din,
  input  logic                  output_V_full_n,
  output logic                  output_V_write
);

  state_e                 state_q, state_d;
  logic [AW-1:0]          addr_q;
  logic [REP_WIDTH-1:0]   rep_q;
  logic [REP_WIDTH-1:0]   reps_last_q;
  logic                   inflight_q;
  occ_t                   occ;
  logic [DATA_WIDTH-1:0]  head;
  logic                   pop;
  logic                   last_read;
  logic                   start_run;

  bias_skid_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .push      (inflight_q),
    .push_data (bias_q),
    .pop       (pop),
    .occ       (occ),
    .head      (head)
  );

  assign pop            = (occ != '0) && output_V_full_n;
  assign output_V_write = pop;
  assign output_V_din   = head;

  assign ap_idle      = (state_q == ST_IDLE);
  assign ap_done      = (state_q == ST_DONE);
  assign ap_ready     = ap_done;
  assign bias_address = addr_q;

  assign start_run = ap_idle && ap_start && (reps_i != '0);
  assign last_read = (addr_q == AW'(MEM_SIZE - 1)) && (rep_q == reps_last_q);

  // Buffered plus in-flight words, net of this cycle's pop, must stay below two.
  assign bias_ce = (state_q == ST_RUN) &&
                   ((3'(occ) + 3'(inflight_q)) < (3'd2 + 3'(pop)));

  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ap_start) state_d = (reps_i == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (bias_ce && last_read) state_d = ST_DRAIN;
      // Leave once the buffer empties at this edge with nothing left to land.
      ST_DRAIN: if (!inflight_q && (occ == occ_t'(pop))) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rep_q       <= '0;
      reps_last_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= bias_ce;
      if (start_run) begin
        addr_q      <= '0;
        rep_q       <= '0;
        reps_last_q <= reps_i - REP_WIDTH'(1);
      end else if (bias_ce) begin
        if (addr_q == AW'(MEM_SIZE - 1)) begin
          addr_q <= '0;
          rep_q  <= rep_q + 1'b1;
        end else begin
          addr_q <= addr_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bias_stream_ctrl.sv
// Self-checking bench for bias_stream_ctrl: a word-level model predicts the
// stream contents, the write strobe, the head word and the run timing.
module tb_bias_stream_ctrl;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int RW = 16;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ap_start;
  logic [RW-1:0] reps;
  logic          ap_idle, ap_done, ap_ready;
  logic [AW-1:0] bias_address;
  logic          bias_ce;
  logic [DW-1:0] bias_q;
  logic [DW-1:0] din;
  logic          full_n;
  logic          write;

  bias_stream_ctrl #(.MEM_SIZE(N), .DATA_WIDTH(DW), .REP_WIDTH(RW)) dut (
    .ap_clk          (clk),
    .ap_rst_n        (rst_n),
    .ap_start        (ap_start),
    .reps_i          (reps),
    .ap_idle         (ap_idle),
    .ap_done         (ap_done),
    .ap_ready        (ap_ready),
    .bias_address    (bias_address),
    .bias_ce         (bias_ce),
    .bias_q          (bias_q),
    .output_V_din    (din),
    .output_V_full_n (full_n),
    .output_V_write  (write)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rom [N];
  initial begin
    rom[0] = 16'd10; rom[1] = 16'd11; rom[2] = 16'd12; rom[3] = 16'd13;
  end

  // External ROM with one cycle of read latency.
  always @(posedge clk) if (bias_ce) bias_q <= rom[bias_address];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Word-level model state, updated by the monitor on falling edges.
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];
  int  wr_total, ce_total, pushes, done_cnt, viol;
  int  first_wr_cyc, last_wr_cyc, done_cyc, done_first_cyc;
  bit  ce_d1, done_prev, mon_en;

  always @(negedge clk) begin
    if (mon_en) begin
      int  mocc;
      bit  exp_write;
      mocc      = pushes - wr_total;
      exp_write = (mocc > 0) && full_n;
      if (write !== exp_write) viol++;
      if (write && !full_n) viol++;
      if (ap_ready !== ap_done) viol++;
      if (mocc > 0) begin
        if (wr_total >= exp_q.size()) viol++;
        else if (din !== exp_q[wr_total]) viol++;
      end
      if (write) begin
        got_q.push_back(din);
        if (wr_total == 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        wr_total++;
      end
      if (ap_done) begin
        if (done_prev) viol++;
        if (done_cnt == 0) done_first_cyc = cyc;
        done_cyc = cyc;
        done_cnt++;
      end
      done_prev = ap_done;
      if (ce_d1) pushes++;
      ce_d1 = bias_ce;
      if (bias_ce) ce_total++;
      if (ce_total - wr_total > 2) viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    wr_total = 0; ce_total = 0; pushes = 0; done_cnt = 0; viol = 0;
    first_wr_cyc = -1; last_wr_cyc = -1; done_cyc = -1; done_first_cyc = -1;
    ce_d1 = 1'b0; done_prev = 1'b0;
  endtask

  task automatic build_exp(input int r, input int runs);
    exp_q.delete();
    for (int k = 0; k < runs * r; k++)
      for (int a = 0; a < N; a++) exp_q.push_back(rom[a]);
  endtask

  task automatic start_pulse(input int r, output int t0);
    step();
    ap_start = 1'b1;
    reps     = RW'(r);
    t0       = cyc;
    step();
    ap_start = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int n, input int budget, input bit rnd);
    for (int i = 0; i < budget && done_cnt < n; i++) begin
      step();
      if (rnd) full_n = 1'($urandom_range(0, 1));
    end
    full_n = 1'b1;
    check({tag, "_done_seen"}, 32'(done_cnt >= n), 32'd1);
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_nwords"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_word%0d", tag, i),
            (i < got_q.size()) ? 32'(got_q[i]) : 32'hdead, 32'(exp_q[i]));
    check({tag, "_protocol"}, 32'(viol), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_idle"},  32'(ap_idle),        32'd1);
    check({tag, "_done"},  32'(ap_done),        32'd0);
    check({tag, "_ready"}, 32'(ap_ready),       32'd0);
    check({tag, "_ce"},    32'(bias_ce),        32'd0);
    check({tag, "_addr"},  32'(bias_address),   32'd0);
    check({tag, "_write"}, 32'(write),          32'd0);
    check({tag, "_din"},   32'(din),            32'd0);
  endtask

  initial begin
    int t0, ce_at_stall;
    rst_n = 1'b0; ap_start = 1'b0; reps = '0; full_n = 1'b1; mon_en = 1'b0;
    clear_mon();
    #2;
    check_reset("por");
    step(); step();
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Free-flowing run: one word per cycle, fixed latency.
    clear_mon(); build_exp(3, 1);
    start_pulse(3, t0);
    run_until_done("flow", 1, 100, 1'b0);
    step(); step();
    check_seq("flow");
    check("flow_first_wr", 32'(first_wr_cyc), 32'(t0 + 3));
    check("flow_last_wr",  32'(last_wr_cyc),  32'(t0 + N * 3 + 2));
    check("flow_done_cyc", 32'(done_cyc),     32'(t0 + N * 3 + 3));
    check("flow_done_cnt", 32'(done_cnt),     32'd1);
    check("flow_ce_total", 32'(ce_total),     32'(N * 3));

    // Random backpressure: same sequence, strobe gated by full_n.
    clear_mon(); build_exp(3, 1);
    start_pulse(3, t0);
    full_n = 1'($urandom_range(0, 1));
    run_until_done("rnd", 1, 500, 1'b1);
    step(); step();
    check_seq("rnd");
    check("rnd_done_cnt", 32'(done_cnt), 32'd1);
    check("rnd_ce_total", 32'(ce_total), 32'(N * 3));

    // Long stall right after the first word.
    clear_mon(); build_exp(3, 1);
    start_pulse(3, t0);
    for (int i = 0; i < 20 && wr_total < 1; i++) step();
    full_n      = 1'b0;
    ce_at_stall = ce_total;
    repeat (20) step();
    check("stall_head",   32'(din),                     32'(rom[1]));
    check("stall_wr",     32'(wr_total),                32'd1);
    check("stall_ce_cap", 32'(ce_total - ce_at_stall <= 2), 32'd1);
    full_n = 1'b1;
    run_until_done("stall", 1, 100, 1'b0);
    step(); step();
    check_seq("stall");

    // Zero repetitions: no traffic, done one cycle after start.
    clear_mon(); exp_q.delete();
    start_pulse(0, t0);
    run_until_done("zero", 1, 20, 1'b0);
    step(); step();
    check("zero_ce",       32'(ce_total), 32'd0);
    check("zero_wr",       32'(wr_total), 32'd0);
    check("zero_done_cyc", 32'(done_cyc), 32'(t0 + 1));
    check("zero_done_cnt", 32'(done_cnt), 32'd1);

    // Asynchronous reset in the middle of a run, then a clean single pass.
    clear_mon(); build_exp(3, 1);
    start_pulse(3, t0);
    for (int i = 0; i < 100 && wr_total < 5; i++) step();
    check("mid_reached", 32'(wr_total >= 5), 32'd1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset("mid_rst");
    step(); step();
    rst_n = 1'b1;
    clear_mon(); build_exp(1, 1);
    mon_en = 1'b1;
    start_pulse(1, t0);
    run_until_done("post_rst", 1, 50, 1'b0);
    step(); step();
    check_seq("post_rst");

    // Start held high: two back-to-back runs separated by one idle cycle.
    clear_mon(); build_exp(1, 2);
    step();
    ap_start = 1'b1;
    reps     = RW'(1);
    t0       = cyc;
    run_until_done("b2b", 2, 100, 1'b0);
    ap_start = 1'b0;
    repeat (4) step();
    check_seq("b2b");
    check("b2b_done_cnt",   32'(done_cnt),                  32'd2);
    check("b2b_first_done", 32'(done_first_cyc),            32'(t0 + N + 3));
    check("b2b_gap",        32'(done_cyc - done_first_cyc), 32'(N + 4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
